// File: rtl/ram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ram_fifo_pkg
// Shared constants and types for the RAM-backed FIFO controller and its
// RAM-port arbiter.
//
// Contents:
//   AW, DW, DEPTH, AF_TH  - address width, data width, RAM entries, and the
//                           almost-full threshold (used only when
//                           RAM_FIFO_LEVEL_EN is defined)
//   ptr_t, cnt_t, data_t  - RAM pointer, occupancy count, payload types
//   grant_t               - which requester owns the RAM port this cycle
//   CNT_FULL              - count value meaning "every RAM entry in use"
//   ptr_inc               - pointer increment that wraps at DEPTH
// ---------------------------------------------------------------------------
package ram_fifo_pkg;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam int AF_TH = 6;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] data_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    // DEPTH is a power of two, so letting the pointer overflow gives the wrap.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/ram_port_arb.sv
// ---------------------------------------------------------------------------
// ram_port_arb
// Two-requester arbiter for the single RAM port. When only one side requests,
// it wins. When both request, the read side wins if prio_rd is set, otherwise
// the write side wins, and prio_rd flips so the loser wins the next contest.
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-low reset
//   flush    in   synchronous clear; returns priority to the read side
//   rd_req   in   refill read wanted
//   wr_req   in   push write wanted
//   grant    out  grant_t owner of the RAM port this cycle
//   prio_rd  out  priority state: 1 = read wins the next contest
// ---------------------------------------------------------------------------
import ram_fifo_pkg::*;

module ram_port_arb (
    input  logic   clk,
    input  logic   clr,
    input  logic   flush,
    input  logic   rd_req,
    input  logic   wr_req,
    output grant_t grant,
    output logic   prio_rd
);

    logic contested;

    // Grant decode: a lone request always wins; a contest goes by prio_rd.
    always_comb begin
        grant     = GNT_NONE;
        contested = rd_req && wr_req;
        if (contested) begin
            grant = prio_rd ? GNT_RD : GNT_WR;
        end else if (wr_req) begin
            grant = GNT_WR;
        end else if (rd_req) begin
            grant = GNT_RD;
        end
    end

    // Priority only moves on contested cycles. Uncontested grants leave it
    // alone, so a long run of lone writes does not bias the next contest.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prio_rd <= 1'b1;
        end else if (flush) begin
            prio_rd <= 1'b1;
        end else if (contested) begin
            prio_rd <= ~prio_rd;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
// FIFO controller in front of the 8x8 single-port RAM. It turns a
// valid/ready push stream and a valid/ready pop stream into at most one RAM
// access per cycle. The RAM holds the payload. This block owns the pointers,
// the occupancy count, and a one-entry output holding register, so the total
// capacity is DEPTH+1.
//
// The RAM writes on the rising clk edge when rw=1 and reads combinationally
// from addr, so a read grant captures ram_dout into the holding register at
// the end of the same cycle.
//
// Optional build macro:
//   RAM_FIFO_LEVEL_EN  - adds level (items held, 0..DEPTH+1) and almost_full
//                        (count >= AF_TH) outputs
//
// Ports:
//   clk         in   rising-edge clock
//   clr         in   asynchronous active-low reset
//   flush       in   synchronous clear of FIFO state, highest priority
//   push_valid  in   producer has data
//   push_data   in   producer payload
//   push_ready  out  push accepted this cycle (write granted)
//   pop_valid   out  holding register holds an item
//   pop_data    out  holding register contents
//   pop_ready   in   consumer takes pop_data this cycle
//   ram_rw      out  RAM write enable (1 = write)
//   ram_clr     out  RAM clear, asserted in reset and on flush
//   ram_addr    out  RAM address
//   ram_din     out  RAM write data
//   ram_dout    in   RAM read data
//   empty       out  nothing in RAM and nothing in the holding register
//   full        out  every RAM entry in use
//   level       out  (RAM_FIFO_LEVEL_EN) count plus holding-register item
//   almost_full out  (RAM_FIFO_LEVEL_EN) count at or above AF_TH
// ---------------------------------------------------------------------------
import ram_fifo_pkg::*;

module ram_fifo_ctrl (
    input  logic          clk,
    input  logic          clr,
    input  logic          flush,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    input  logic          pop_ready,
    output logic          ram_rw,
    output logic          ram_clr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          empty,
    output logic          full
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [AW+1:0] level,
    output logic          almost_full
`endif
);

    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    cnt_t   count;
    data_t  dout_reg;
    logic   dout_valid;
    logic   active;
    logic   rd_req;
    logic   wr_req;
    grant_t grant;
    logic   prio_rd_unused;

    // active is cleared by reset and set by the first clock edge after reset
    // is released. Gating writes with it keeps push_ready and ram_rw low for
    // the whole reset interval, even when push_valid is high, without routing
    // clr into the datapath. As a result, pushes are accepted from the cycle
    // after release onward.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // Requests use registered state only, so pop_ready has no combinational
    // path to the RAM port. A pop frees the holding register at the edge,
    // and the refill read is requested the following cycle. Flush suppresses
    // both requests because its edge discards everything anyway.
    always_comb begin
        rd_req = !dout_valid && (count != '0) && !flush;
        wr_req = active && push_valid && (count < CNT_FULL) && !flush;
    end

    ram_port_arb u_arb (
        .clk     (clk),
        .clr     (clr),
        .flush   (flush),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .grant   (grant),
        .prio_rd (prio_rd_unused)
    );

    // RAM port drive. When idle, the port parks on rd_ptr with rw low, so the
    // RAM output always shows the next item to be read.
    always_comb begin
        ram_rw     = 1'b0;
        ram_addr   = rd_ptr;
        ram_din    = '0;
        push_ready = 1'b0;
        if (grant == GNT_WR) begin
            ram_rw     = 1'b1;
            ram_addr   = wr_ptr;
            ram_din    = push_data;
            push_ready = 1'b1;
        end
    end

    assign ram_clr   = ~clr | flush;
    assign pop_valid = dout_valid;
    assign pop_data  = dout_reg;
    assign empty     = (count == '0) && !dout_valid;
    assign full      = (count == CNT_FULL);

    // Pointers and count. Reads and writes are mutually exclusive, so count
    // moves by at most one per cycle. Flush takes precedence over any grant.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (grant)
                GNT_WR: begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    count  <= count + cnt_t'(1);
                end
                GNT_RD: begin
                    rd_ptr <= ptr_inc(rd_ptr);
                    count  <= count - cnt_t'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Holding register. A read grant only happens while the register is
    // empty, so it never collides with a pop in the same cycle. Flush drops
    // the valid flag, which also covers a pop that coincides with the flush.
    // The data is left as is.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dout_reg   <= '0;
            dout_valid <= 1'b0;
        end else if (flush) begin
            dout_valid <= 1'b0;
        end else if (grant == GNT_RD) begin
            dout_reg   <= ram_dout;
            dout_valid <= 1'b1;
        end else if (dout_valid && pop_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef RAM_FIFO_LEVEL_EN
    // Occupancy view for upstream throttling. It reads zero during a flush
    // cycle because everything is discarded at that edge.
    always_comb begin
        level       = '0;
        almost_full = 1'b0;
        if (!flush) begin
            level       = {1'b0, count} + {{(AW+1){1'b0}}, dout_valid};
            almost_full = (count >= cnt_t'(AF_TH));
        end
    end
`endif

endmodule
